rca_completion_ctrl: RTL

Sequential launch/capture controller wrapped around the ripple-carry adder. It accepts operands over a valid/ready handshake and drives them into the RCA. It reads back the RCA propagate vector P and derives a data-dependent wait from the longest carry-propagate run. After that wait it captures {Cout,S} and returns the result on a second valid/ready handshake. This turns the RCA's variable settle time into a variable but bounded clock-cycle latency.

---
 rtl/rca_completion_ctrl_if.sv | 28 ++
 rtl/rca_completion_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/rca_completion_ctrl_if.sv
// Operand request and result return handshakes between a client and rca_completion_ctrl.
// The client drives the master side; the controller takes the slave side.
interface rca_completion_ctrl_if #(
   parameter int N = 16,
   parameter int K = 4
);
   localparam int LW = $clog2(N/K+2);

   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_a;
   logic [N-1:0]  in_b;
   logic          in_cin;
   logic          out_valid;
   logic          out_ready;
   logic [N:0]    out_sum;
   logic [LW-1:0] out_lat;

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_lat
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_lat
   );
endinterface

// File: rtl/rca_completion_ctrl.sv
// Launches operands into an external RCA, waits floor(L/K)+1 cycles (L = longest propagate run), then captures {Cout,S}.
// Latency W+1 edges from accept to out_valid; one operation in flight, result held until out_ready.
module rca_completion_ctrl #(
   parameter int N = 16,
   parameter int K = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   rca_completion_ctrl_if.slave bus,
   output logic [N-1:0]         rca_a,
   output logic [N-1:0]         rca_b,
   output logic                 rca_cin,
   input  logic [N-1:0]         rca_s,
   input  logic                 rca_cout,
   input  logic [N-1:0]         rca_p,
   output logic [31:0]          perf_cycles
);
   localparam int LW = $clog2(N/K+2);
   localparam int RW = $clog2(N+1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          accept;
   logic          capture;
   logic [LW-1:0] cnt;
   logic [LW-1:0] lat_q;
   logic [N:0]    sum_q;
   logic [RW-1:0] run_len;
   logic [RW-1:0] run_max;
   logic [LW-1:0] w_val;

   // Longest run of consecutive propagate bits bounds the carry ripple distance.
   always_comb begin
      run_len = '0;
      run_max = '0;
      for (int i = 0; i < N; i++) begin
         if (rca_p[i]) run_len = run_len + RW'(1);
         else          run_len = '0;
         if (run_len > run_max) run_max = run_len;
      end
   end

   assign w_val = LW'(run_max / RW'(K)) + LW'(1);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.in_valid) begin
               accept    = 1'b1;
               state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: state_nxt = S_WAIT;
         S_WAIT: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rca_a       <= '0;
         rca_b       <= '0;
         rca_cin     <= 1'b0;
         cnt         <= '0;
         lat_q       <= '0;
         sum_q       <= '0;
         perf_cycles <= '0;
      end else begin
         if (accept) begin
            rca_a   <= bus.in_a;
            rca_b   <= bus.in_b;
            rca_cin <= bus.in_cin;
         end
         if (state == S_LAUNCH) begin
            cnt   <= w_val - LW'(1);
            lat_q <= w_val;
         end
         if (state == S_WAIT) begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (cnt != '0)         cnt <= cnt - LW'(1);
         end
         if (capture) sum_q <= {rca_cout, rca_s};
      end
   end

   assign bus.in_ready  = (state == S_IDLE) && !rst;
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_sum   = sum_q;
   assign bus.out_lat   = lat_q;
endmodule
